// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default sizes for the I/D memory arbiter
package mem_arb_pkg;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int WORDS_DEF   = 8;
  localparam int LATENCY_DEF = 4;
  localparam int WORD_BITS   = $clog2(WORDS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    FILL_I,
    FILL_D,
    WRITE_D,
    DRAIN
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I-port, D-port and memory-side signals of the arbiter
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int WB = WORD_BITS
) ();

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_grant;
  logic          i_valid;
  logic [WB-1:0] i_word;
  logic [DW-1:0] i_data;
  logic          i_done;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_grant;
  logic          d_valid;
  logic [WB-1:0] d_word;
  logic [DW-1:0] d_data;
  logic          d_done;

  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_grant, i_valid, i_word, i_data, i_done,
    output d_grant, d_valid, d_word, d_data, d_done,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  // Cache controllers plus memory side
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_grant, i_valid, i_word, i_data, i_done,
    input  d_grant, d_valid, d_word, d_data, d_done,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_ret_pipe.sv
// rtl/arb_ret_pipe.sv - fixed-latency tracker of issued reads {valid, word, last}
module arb_ret_pipe #(
  parameter int LATENCY = 4,
  parameter int WB      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [WB-1:0] in_word,
  input  logic          in_last,
  output logic          out_valid,
  output logic [WB-1:0] out_word,
  output logic          out_last
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] last_q;
  logic [WB-1:0]      word_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < LATENCY; i++) word_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_last;
      word_q[0]  <= in_word;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
        word_q[i]  <= word_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_last  = valid_q[LATENCY-1] & last_q[LATENCY-1];
  assign out_word  = word_q[LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sequencing I/D line fills and D write-throughs
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int WB = $clog2(WORDS);

  state_e        state_q, state_d;
  owner_e        last_owner_q, last_owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [WB-1:0] cnt_q, cnt_d;

  logic          issue;
  logic          is_write;
  logic          ret_valid;
  logic [WB-1:0] ret_word;
  logic          ret_last;
  logic [AW-1:0] fill_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    issue        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On contention the port that did not own the last transaction wins
        if (bus.d_req && (!bus.i_req || last_owner_q == OWN_I)) begin
          last_owner_d = OWN_D;
          addr_d       = bus.d_addr;
          wdata_d      = bus.d_wdata;
          state_d      = bus.d_wr ? WRITE_D : FILL_D;
        end else if (bus.i_req) begin
          last_owner_d = OWN_I;
          addr_d       = bus.i_addr;
          state_d      = FILL_I;
        end
      end
      FILL_I, FILL_D: begin
        issue = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WB'(WORDS - 1)) state_d = DRAIN;
      end
      WRITE_D: state_d = IDLE;
      DRAIN:   if (ret_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  arb_ret_pipe #(
    .LATENCY (LATENCY),
    .WB      (WB)
  ) u_ret_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_word   (cnt_q),
    .in_last   (cnt_q == WB'(WORDS - 1)),
    .out_valid (ret_valid),
    .out_word  (ret_word),
    .out_last  (ret_last)
  );

  // Line-aligned base with the word counter spliced in at the 16-bit word stride
  assign fill_addr = {addr_q[AW-1:WB+1], cnt_q, 1'b0};
  assign is_write  = (state_q == WRITE_D);

  assign bus.mem_en    = issue | is_write;
  assign bus.mem_wr    = is_write;
  assign bus.mem_addr  = is_write ? addr_q : (issue ? fill_addr : '0);
  assign bus.mem_wdata = is_write ? wdata_q : '0;

  assign bus.i_grant = (state_q == FILL_I) | ((state_q == DRAIN) & (last_owner_q == OWN_I));
  assign bus.d_grant = (state_q == FILL_D) | is_write |
                       ((state_q == DRAIN) & (last_owner_q == OWN_D));

  assign bus.i_valid = ret_valid & (last_owner_q == OWN_I);
  assign bus.d_valid = ret_valid & (last_owner_q == OWN_D);
  assign bus.i_word  = ret_word;
  assign bus.d_word  = ret_word;
  assign bus.i_done  = ret_last & (last_owner_q == OWN_I);
  assign bus.d_done  = (ret_last & (last_owner_q == OWN_D)) | is_write;
  assign bus.i_data  = bus.mem_rdata;
  assign bus.d_data  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter (8x4 and 2x1 configurations)
module tb_mem_arbiter;

  logic clk;
  logic rst0;
  logic rst1;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if #(.AW(16), .DW(16), .WB(3)) bus0 ();
  mem_arbiter_if #(.AW(16), .DW(16), .WB(1)) bus1 ();

  mem_arbiter #(.AW(16), .DW(16), .WORDS(8), .LATENCY(4)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  mem_arbiter #(.AW(16), .DW(16), .WORDS(2), .LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data is the issued address scrambled, LATENCY cycles later
  logic [15:0] hist0 [4];
  logic [15:0] hist1 [1];
  always @(posedge clk) begin
    hist0[0] <= bus0.mem_addr;
    for (int i = 1; i < 4; i++) hist0[i] <= hist0[i-1];
    hist1[0] <= bus1.mem_addr;
  end
  assign bus0.mem_rdata = hist0[3] ^ 16'hA5A5;
  assign bus1.mem_rdata = hist1[0] ^ 16'hA5A5;

  // {en, wr, ig, iv, idone, dg, dv, ddone, iword, dword, addr, wdata}
  function automatic logic [45:0] obs0();
    return {bus0.mem_en, bus0.mem_wr, bus0.i_grant, bus0.i_valid, bus0.i_done,
            bus0.d_grant, bus0.d_valid, bus0.d_done,
            bus0.i_valid ? bus0.i_word : 3'd0, bus0.d_valid ? bus0.d_word : 3'd0,
            bus0.mem_addr, bus0.mem_wdata};
  endfunction

  function automatic logic [45:0] obs1();
    return {bus1.mem_en, bus1.mem_wr, bus1.i_grant, bus1.i_valid, bus1.i_done,
            bus1.d_grant, bus1.d_valid, bus1.d_done,
            bus1.i_valid ? {2'b0, bus1.i_word} : 3'd0, bus1.d_valid ? {2'b0, bus1.d_word} : 3'd0,
            bus1.mem_addr, bus1.mem_wdata};
  endfunction

  // Expected outputs of one fill whose first issue is cycle s
  function automatic logic [45:0] exp_fill(int c, int s, logic [15:0] base, bit is_d,
                                           int words, int lat);
    logic [45:0] v;
    int k;
    v = '0;
    k = c - s - lat;
    if (c >= s && c < s + words) begin
      v[45] = 1'b1;
      v[31:16] = base + 16'(2 * (c - s));
    end
    if (c >= s && c < s + words + lat) v[is_d ? 40 : 43] = 1'b1;
    if (k >= 0 && k < words) begin
      v[is_d ? 39 : 42] = 1'b1;
      if (k == words - 1) v[is_d ? 38 : 41] = 1'b1;
      if (is_d) v[34:32] = 3'(k);
      else      v[37:35] = 3'(k);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.i_req = 0; bus0.i_addr = '0; bus0.d_req = 0; bus0.d_wr = 0;
    bus0.d_addr = '0; bus0.d_wdata = '0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_wr = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst0 = 1; rst1 = 1;
    tick();
    tick();
    rst0 = 0; rst1 = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst0 = 1; rst1 = 1;
    bus0.i_req = 1; bus0.d_req = 1;
    tick();
    tick();
    n_cmp++;
    if (obs0() !== 46'd0) begin
      n_bad++; $display("FAIL reset_dut0 got %h exp %h", obs0(), 46'd0);
    end
    n_cmp++;
    if (obs1() !== 46'd0) begin
      n_bad++; $display("FAIL reset_dut1 got %h exp %h", obs1(), 46'd0);
    end
    rst0 = 0; rst1 = 0;
    clear_inputs();
    tick();
    n_cmp++;
    if (obs0() !== 46'd0) begin
      n_bad++; $display("FAIL reset_idle got %h exp %h", obs0(), 46'd0);
    end
  endtask

  task automatic test_i_fill();
    logic [45:0] e;
    logic [15:0] ed;
    do_reset();
    bus0.i_req = 1; bus0.i_addr = 16'h0046;
    for (int c = 1; c <= 13; c++) begin
      tick();
      e = exp_fill(c, 1, 16'h0040, 0, 8, 4);
      n_cmp++;
      if (obs0() !== e) begin
        n_bad++; $display("FAIL i_fill c=%0d got %h exp %h", c, obs0(), e);
      end
      if (c >= 5 && c <= 12) begin
        ed = (16'h0040 + 16'(2 * (c - 5))) ^ 16'hA5A5;
        n_cmp++;
        if (bus0.i_data !== ed) begin
          n_bad++; $display("FAIL i_data c=%0d got %h exp %h", c, bus0.i_data, ed);
        end
      end
      if (c == 1) bus0.i_addr = 16'hFFFF;
      if (c == 12) bus0.i_req = 0;
    end
  endtask

  task automatic test_both_fill();
    logic [45:0] e;
    do_reset();
    bus0.d_req = 1; bus0.d_wr = 0; bus0.d_addr = 16'h1234;
    bus0.i_req = 1; bus0.i_addr = 16'h0200;
    for (int c = 1; c <= 26; c++) begin
      tick();
      e = exp_fill(c, 1, 16'h1230, 1, 8, 4) | exp_fill(c, 14, 16'h0200, 0, 8, 4);
      n_cmp++;
      if (obs0() !== e) begin
        n_bad++; $display("FAIL both_fill c=%0d got %h exp %h", c, obs0(), e);
      end
      if (c == 12) bus0.d_req = 0;
      if (c == 25) bus0.i_req = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [45:0] e;
    do_reset();
    bus0.d_req = 1; bus0.d_wr = 0; bus0.d_addr = 16'h1234;
    bus0.i_req = 1; bus0.i_addr = 16'h0200;
    for (int c = 1; c <= 40; c++) begin
      tick();
      e = exp_fill(c, 1, 16'h1230, 1, 8, 4) | exp_fill(c, 14, 16'h0200, 0, 8, 4) |
          exp_fill(c, 27, 16'h1230, 1, 8, 4);
      n_cmp++;
      if (obs0() !== e) begin
        n_bad++; $display("FAIL back_to_back c=%0d got %h exp %h", c, obs0(), e);
      end
      if (c == 38) begin
        bus0.d_req = 0; bus0.i_req = 0;
      end
    end
  endtask

  task automatic test_write();
    logic [45:0] e;
    do_reset();
    bus0.d_req = 1; bus0.d_wr = 1; bus0.d_addr = 16'h0100; bus0.d_wdata = 16'hBEEF;
    bus0.i_req = 1; bus0.i_addr = 16'h0300;
    for (int c = 1; c <= 15; c++) begin
      tick();
      e = exp_fill(c, 3, 16'h0300, 0, 8, 4);
      if (c == 1) e = {1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 6'd0, 16'h0100, 16'hBEEF};
      n_cmp++;
      if (obs0() !== e) begin
        n_bad++; $display("FAIL write c=%0d got %h exp %h", c, obs0(), e);
      end
      if (c == 1) begin
        bus0.d_req = 0; bus0.d_wr = 0; bus0.d_addr = 16'h5555;
      end
      if (c == 14) bus0.i_req = 0;
    end
    bus0.d_req = 1; bus0.d_wr = 1; bus0.d_addr = 16'h0107; bus0.d_wdata = 16'h1234;
    tick();
    e = {1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 6'd0, 16'h0107, 16'h1234};
    n_cmp++;
    if (obs0() !== e) begin
      n_bad++; $display("FAIL write_odd got %h exp %h", obs0(), e);
    end
    bus0.d_req = 0; bus0.d_wr = 0;
    tick();
  endtask

  task automatic test_rst_mid();
    logic [45:0] e;
    do_reset();
    bus0.i_req = 1; bus0.i_addr = 16'h0046;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 7) rst0 = 0;
      e = (c <= 6) ? exp_fill(c, 1, 16'h0040, 0, 8, 4) : 46'd0;
      n_cmp++;
      if (obs0() !== e) begin
        n_bad++; $display("FAIL rst_mid c=%0d got %h exp %h", c, obs0(), e);
      end
      if (c == 6) begin
        rst0 = 1; bus0.i_req = 0;
      end
    end
    bus0.i_req = 1; bus0.i_addr = 16'h0080;
    for (int c = 1; c <= 13; c++) begin
      tick();
      e = exp_fill(c, 1, 16'h0080, 0, 8, 4);
      n_cmp++;
      if (obs0() !== e) begin
        n_bad++; $display("FAIL rst_refill c=%0d got %h exp %h", c, obs0(), e);
      end
      if (c == 12) bus0.i_req = 0;
    end
  endtask

  task automatic test_small_config();
    logic [45:0] e;
    do_reset();
    bus1.i_req = 1; bus1.i_addr = 16'h0046;
    for (int c = 1; c <= 5; c++) begin
      tick();
      e = exp_fill(c, 1, 16'h0044, 0, 2, 1);
      n_cmp++;
      if (obs1() !== e) begin
        n_bad++; $display("FAIL small_i c=%0d got %h exp %h", c, obs1(), e);
      end
      if (c == 3) bus1.i_req = 0;
    end
    bus1.d_req = 1; bus1.d_wr = 0; bus1.d_addr = 16'h1237;
    for (int c = 1; c <= 4; c++) begin
      tick();
      e = exp_fill(c, 1, 16'h1234, 1, 2, 1);
      n_cmp++;
      if (obs1() !== e) begin
        n_bad++; $display("FAIL small_d c=%0d got %h exp %h", c, obs1(), e);
      end
      if (c == 3) bus1.d_req = 0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_inputs();
    rst0 = 1;
    rst1 = 1;
    test_reset();
    test_i_fill();
    test_both_fill();
    test_back_to_back();
    test_write();
    test_rst_mid();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified, pipelined main memory between the instruction-cache fill path (I port) and the data-cache fill/write path (D port).
- Sits between the two cache controllers and main memory. It sequences line fills as back-to-back word reads and single-word write-throughs.
- Arbitrates round-robin when both ports request at once.
- The pipeline stalls on the requester's grant until its done pulse.

Parameters:
- AW, 16: address width (byte address; 16-bit words, so word stride is 2).
- DW, 16: data width.
- WORDS, 8: words per cache line; must be a power of two, at least 2.
- LATENCY, 4: fixed cycles from a read address being issued to mem_rdata being valid; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-side line fill request; held with i_addr until i_done
- i_addr  in  AW  any byte address within the line to fill
- i_grant  out  1  high from first issue cycle through the i_done cycle
- i_valid  out  1  i_data carries fill word i_word this cycle
- i_word  out  log2(WORDS)  index of returned word
- i_data  out  DW  fill data
- i_done  out  1  one-cycle pulse with the last fill word
- d_req  in  1  D-side request; held with address, write flag and write data until d_done
- d_wr  in  1  1 = single-word write, 0 = line fill
- d_addr  in  AW  byte address
- d_wdata  in  DW  write data
- d_grant, d_valid, d_word, d_data, d_done  out  same meaning as the I-side outputs
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid LATENCY cycles after issue

Behaviour:
- Reset: rst=1 at an edge gives state IDLE, all counters and the return pipe cleared, last_owner=I. All 1-bit outputs and mem_addr/mem_wdata are 0 the next cycle.
- Data buses: i_data and d_data are both driven by mem_rdata unqualified; consumers qualify them with the valid signals.
- States: IDLE, FILL_I, FILL_D, WRITE_D, DRAIN.
- IDLE arbitration: decided from registered state at the clock edge.
  - d_req only: go to FILL_D or WRITE_D according to d_wr.
  - i_req only: go to FILL_I.
  - Both: grant the port that was not last_owner. After reset this means D wins first.
  - last_owner is updated on each grant.
- Fill base address: addr with its low log2(WORDS)+1 bits cleared. Word k is at base + 2k.
- FILL_x: WORDS consecutive cycles with mem_en=1, mem_wr=0, mem_addr = base + 2·issue_cnt. Then go to DRAIN.
- DRAIN: waits until the last word returns, then goes to IDLE. No issues occur in DRAIN.
- Return pipe: a LATENCY-deep shift register of {valid, word index}.
  - An issue in cycle t produces x_valid=1 and x_word=k in cycle t+LATENCY.
  - x_done is asserted with word WORDS-1.
  - The grant covers cycles 1 through WORDS+LATENCY, counted from the first issue cycle.
- WRITE_D: one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr (unaligned bit 0 passed through), mem_wdata=d_wdata.
  - d_grant=1 and d_done=1 in that same cycle; d_valid stays 0.
  - Go to IDLE.
- Idle gap: at least one IDLE cycle between transactions. The next grant is taken from IDLE.
- Request dropped mid-transaction: illegal. The arbiter completes the transaction and still pulses done.
- Changes to address or write flag after grant are ignored; they are latched at grant.
- rst mid-transaction: abort immediately and clear the pipe. Data still in flight in memory produces no valid/done. Requests are re-evaluated from IDLE after rst deasserts.
- No combinational path from any input to any output other than mem_rdata to i_data/d_data.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, FILL_I, FILL_D, WRITE_D, DRAIN}.
  - owner enum {OWN_I, OWN_D}.
  - Default constants for AW, DW, WORDS, LATENCY.
  - WORD_BITS = log2(WORDS).
- One sub-module, arb_ret_pipe: a parameterised LATENCY-stage shift register of {valid, word index, last}, with synchronous clear on rst.

Test Plan (WORDS=8, LATENCY=4; cycle 0 is the cycle the request is sampled in IDLE):
- I fill alone, i_addr=0x0046:
  - mem_addr 0x0040, 0x0042 … 0x004E in cycles 1–8.
  - i_valid in cycles 5–12 with i_word 0–7.
  - i_done in cycle 12; i_grant high in cycles 1–12; d_* outputs 0 throughout.
- d_req(fill, 0x1234) and i_req(0x0200) both raised at cycle 0 after reset:
  - D served first with base 0x1230 and d_done in cycle 12.
  - FILL_I issues 0x0200 in the first cycle after the following IDLE cycle.
- Both ports requesting continuously for 3 transactions: grant order D, I, D, with no overlap of grant windows.
- d_req with d_wr=1, d_addr=0x0100, d_wdata=0xBEEF, and i_req held:
  - Cycle 1: mem_en=1, mem_wr=1, mem_addr=0x0100, mem_wdata=0xBEEF, d_done=1.
  - The I fill starts after the next IDLE cycle.
- rst pulsed in cycle 6 of an I fill:
  - The next cycle shows all strobes 0, and no i_valid or i_done ever appears for that fill.
  - A new i_req(0x0080) after rst completes normally with i_word 0–7.
- LATENCY=1, WORDS=2 configuration: i_valid in cycles 2–3, i_done in cycle 3, DRAIN lasts 1 cycle.
